// File: rtl/deadlock_stall_watchdog_pkg.sv
// Shared types and default sizing for the deadlock stall watchdog.
// The state encoding is visible on the debug port, so the values are fixed.
package deadlock_wd_pkg;

    localparam int unsigned DEF_CNT_W          = 32;
    localparam int unsigned DEF_WARN_CYCLES    = 1000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        WARNED = 2'd2,
        DEAD   = 2'd3
    } wd_state_t;

endpackage

// File: rtl/deadlock_stall_watchdog_if.sv
// Bundle of the watchdog's control inputs and status outputs.
// The master side (harness) drives the controls; the slave side (watchdog)
// drives the statistics and flags.
interface deadlock_stall_watchdog_if
    import deadlock_wd_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             enable;
    logic             block;
    logic             inst_idle;
    logic             clear;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] max_stall;
    logic [CNT_W-1:0] episode_count;
    logic             warn_pulse;
    logic             deadlock_pulse;
    logic             deadlock;
    logic             finish_req;
    logic [1:0]       state_o;

    modport master (
        output enable, block, inst_idle, clear,
        input  stall_count, max_stall, episode_count,
        input  warn_pulse, deadlock_pulse, deadlock, finish_req, state_o
    );

    modport slave (
        input  enable, block, inst_idle, clear,
        output stall_count, max_stall, episode_count,
        output warn_pulse, deadlock_pulse, deadlock, finish_req, state_o
    );
endinterface

// File: rtl/deadlock_stall_watchdog_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping, with a
// synchronous clear to zero that takes priority over counting.
module sat_counter
    import deadlock_wd_pkg::*;
#(
    parameter int unsigned W = DEF_CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         load_zero,
    output logic [W-1:0] count
);

    // Clear wins, otherwise step by one unless already saturated.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load_zero) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/deadlock_stall_watchdog.sv
// Stall watchdog placed behind the HLS deadlock monitor: times consecutive
// qualified stalls, pulses a warning, then latches a sticky deadlock flag
// (mirrored on finish_req) and keeps stall statistics for reporting.
module deadlock_stall_watchdog
    import deadlock_wd_pkg::*;
#(
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned WARN_CYCLES    = DEF_WARN_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                      clock,
    input logic                      reset,
    deadlock_stall_watchdog_if.slave bus
);

    localparam longint unsigned CNT_MAX   = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] WARN_V    = CNT_W'(WARN_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               WARN_ON   = (WARN_CYCLES != 0);

    // The timeout must sit strictly above the warning and below counter saturation.
    generate
        if (!((WARN_CYCLES < TIMEOUT_CYCLES) && (64'(TIMEOUT_CYCLES) < CNT_MAX))) begin : g_bad_cfg
            $error("deadlock_stall_watchdog: need WARN_CYCLES < TIMEOUT_CYCLES < 2**CNT_W-1");
        end
    endgenerate

    wd_state_t        state_q, state_d;
    logic             qb;
    logic             stall_inc, stall_zero, ep_inc, ep_zero;
    logic             warn_d, dead_pulse_d, deadlock_d;
    logic             warn_q, dead_pulse_q, deadlock_q;
    logic [CNT_W-1:0] stall_q, stall_plus1, stall_d;
    logic [CNT_W-1:0] ep_q;
    logic [CNT_W-1:0] max_q, max_d;

    assign qb          = bus.enable & bus.block & ~bus.inst_idle;
    assign stall_plus1 = stall_q + CNT_W'(1);
    assign stall_d     = stall_zero ? '0 : (stall_inc ? stall_plus1 : stall_q);
    assign max_d       = bus.clear ? '0 : ((stall_d > max_q) ? stall_d : max_q);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock     (clock),
        .reset     (reset),
        .inc       (stall_inc),
        .load_zero (stall_zero),
        .count     (stall_q)
    );

    sat_counter #(.W(CNT_W)) u_episode_cnt (
        .clock     (clock),
        .reset     (reset),
        .inc       (ep_inc),
        .load_zero (ep_zero),
        .count     (ep_q)
    );

    // Next state, counter controls and pulse requests; clear overrides everything, DEAD ignores the stall input.
    always_comb begin
        state_d      = state_q;
        stall_inc    = 1'b0;
        stall_zero   = 1'b0;
        ep_inc       = 1'b0;
        ep_zero      = 1'b0;
        warn_d       = 1'b0;
        dead_pulse_d = 1'b0;
        deadlock_d   = deadlock_q;
        if (bus.clear) begin
            state_d    = IDLE;
            stall_zero = 1'b1;
            ep_zero    = 1'b1;
            deadlock_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, STALL: begin
                    if (qb) begin
                        stall_inc = 1'b1;
                        ep_inc    = (state_q == IDLE);
                        state_d   = STALL;
                        if (WARN_ON && (stall_plus1 == WARN_V)) begin
                            state_d = WARNED;
                            warn_d  = 1'b1;
                        end else if (stall_plus1 == TIMEOUT_V) begin
                            state_d      = DEAD;
                            dead_pulse_d = 1'b1;
                            deadlock_d   = 1'b1;
                        end
                    end else begin
                        state_d    = IDLE;
                        stall_zero = 1'b1;
                    end
                end
                WARNED: begin
                    if (qb) begin
                        stall_inc = 1'b1;
                        if (stall_plus1 == TIMEOUT_V) begin
                            state_d      = DEAD;
                            dead_pulse_d = 1'b1;
                            deadlock_d   = 1'b1;
                        end
                    end else begin
                        state_d    = IDLE;
                        stall_zero = 1'b1;
                    end
                end
                DEAD: begin
                end
                default: begin
                    state_d    = IDLE;
                    stall_zero = 1'b1;
                end
            endcase
        end
    end

    // State, pulses, sticky flag and longest-stall register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            warn_q       <= 1'b0;
            dead_pulse_q <= 1'b0;
            deadlock_q   <= 1'b0;
            max_q        <= '0;
        end else begin
            state_q      <= state_d;
            warn_q       <= warn_d;
            dead_pulse_q <= dead_pulse_d;
            deadlock_q   <= deadlock_d;
            max_q        <= max_d;
        end
    end

    assign bus.stall_count    = stall_q;
    assign bus.max_stall      = max_q;
    assign bus.episode_count  = ep_q;
    assign bus.warn_pulse     = warn_q;
    assign bus.deadlock_pulse = dead_pulse_q;
    assign bus.deadlock       = deadlock_q;
    assign bus.finish_req     = deadlock_q;
    assign bus.state_o        = state_q;

endmodule

// File: tb/tb_deadlock_stall_watchdog.sv
// Directed bench for the stall watchdog: two instances (with and without a
// warning threshold) share clock and reset; expected outputs are queued as
// each cycle's stimulus is driven and popped one cycle later for comparison.
module tb_deadlock_stall_watchdog;
    import deadlock_wd_pkg::*;

    localparam int unsigned CW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        bit          sel;
        string       tag;
        int unsigned sc;
        int unsigned mx;
        int unsigned ep;
        bit          warn;
        bit          dp;
        bit          dl;
        int unsigned st;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    deadlock_stall_watchdog_if #(.CNT_W(CW)) bus_a ();
    deadlock_stall_watchdog_if #(.CNT_W(CW)) bus_b ();

    deadlock_stall_watchdog #(.CNT_W(CW), .WARN_CYCLES(8), .TIMEOUT_CYCLES(16)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    deadlock_stall_watchdog #(.CNT_W(CW), .WARN_CYCLES(0), .TIMEOUT_CYCLES(16)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic pushExp(input bit sel, input string tag, input int unsigned sc, input int unsigned mx,
                           input int unsigned ep, input bit warn, input bit dp, input bit dl,
                           input int unsigned st);
        exp_t e;
        e.sel = sel; e.tag = tag; e.sc = sc; e.mx = mx; e.ep = ep;
        e.warn = warn; e.dp = dp; e.dl = dl; e.st = st;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] sc, mx, ep;
        logic        w, dp, dl, fr;
        logic [1:0]  st;
        compareVal("scoreboard_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (!e.sel) begin
            sc = 32'(bus_a.stall_count); mx = 32'(bus_a.max_stall); ep = 32'(bus_a.episode_count);
            w = bus_a.warn_pulse; dp = bus_a.deadlock_pulse; dl = bus_a.deadlock;
            fr = bus_a.finish_req; st = bus_a.state_o;
        end else begin
            sc = 32'(bus_b.stall_count); mx = 32'(bus_b.max_stall); ep = 32'(bus_b.episode_count);
            w = bus_b.warn_pulse; dp = bus_b.deadlock_pulse; dl = bus_b.deadlock;
            fr = bus_b.finish_req; st = bus_b.state_o;
        end
        compareVal({e.tag, ".stall_count"},    sc, e.sc);
        compareVal({e.tag, ".max_stall"},      mx, e.mx);
        compareVal({e.tag, ".episode_count"},  ep, e.ep);
        compareVal({e.tag, ".warn_pulse"},     32'(w), 32'(e.warn));
        compareVal({e.tag, ".deadlock_pulse"}, 32'(dp), 32'(e.dp));
        compareVal({e.tag, ".deadlock"},       32'(dl), 32'(e.dl));
        compareVal({e.tag, ".finish_req"},     32'(fr), 32'(e.dl));
        compareVal({e.tag, ".state"},          32'(st), e.st);
    endtask

    task automatic applyStimulus(input bit sel, input logic en, input logic blk, input logic idl,
                                 input logic clr, input string tag, input int unsigned sc,
                                 input int unsigned mx, input int unsigned ep, input bit warn,
                                 input bit dp, input bit dl, input int unsigned st);
        if (!sel) begin
            bus_a.enable = en; bus_a.block = blk; bus_a.inst_idle = idl; bus_a.clear = clr;
        end else begin
            bus_b.enable = en; bus_b.block = blk; bus_b.inst_idle = idl; bus_b.clear = clr;
        end
        pushExp(sel, tag, sc, mx, ep, warn, dp, dl, st);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    initial begin
        int unsigned sc, mx, ep, st;
        bit          idl;

        bus_a.enable = 1'b0; bus_a.block = 1'b0; bus_a.inst_idle = 1'b0; bus_a.clear = 1'b0;
        bus_b.enable = 1'b0; bus_b.block = 1'b0; bus_b.inst_idle = 1'b0; bus_b.clear = 1'b0;

        repeat (2) @(posedge clock);
        #3;
        $display("[TB] reset state");
        pushExp(0, "reset_a", 0, 0, 0, 0, 0, 0, IDLE);
        checkOutput();
        pushExp(1, "reset_b", 0, 0, 0, 0, 0, 0, IDLE);
        checkOutput();
        reset = 1'b0;

        $display("[TB] short stall of 5 cycles");
        for (int i = 1; i <= 5; i++)
            applyStimulus(0, 1, 1, 0, 0, $sformatf("t1_c%0d", i), i, i, 1, 0, 0, 0, STALL);
        applyStimulus(0, 1, 0, 0, 0, "t1_end", 0, 5, 1, 0, 0, 0, IDLE);

        $display("[TB] long stall through warning into deadlock");
        for (int i = 1; i <= 20; i++) begin
            sc = (i > 16) ? 16 : i;
            mx = (sc > 5) ? sc : 5;
            st = (i < 8) ? STALL : ((i < 16) ? WARNED : DEAD);
            applyStimulus(0, 1, 1, 0, 0, $sformatf("t2_c%0d", i), sc, mx, 2, (i == 8), (i == 16), (i >= 16), st);
        end
        applyStimulus(0, 0, 0, 0, 0, "t2_dead_hold_disabled", 16, 16, 2, 0, 0, 1, DEAD);

        $display("[TB] clear out of deadlock with block high");
        applyStimulus(0, 1, 1, 0, 1, "t3_clear", 0, 0, 0, 0, 0, 0, IDLE);
        applyStimulus(0, 1, 1, 0, 0, "t3_restart", 1, 1, 1, 0, 0, 0, STALL);
        applyStimulus(0, 1, 0, 0, 1, "t3_clear2", 0, 0, 0, 0, 0, 0, IDLE);

        $display("[TB] stall split by instance idle");
        for (int i = 1; i <= 12; i++) begin
            idl = (i >= 4) && (i <= 6);
            if (i <= 3) begin
                sc = i; mx = i; ep = 1; st = STALL;
            end else if (idl) begin
                sc = 0; mx = 3; ep = 1; st = IDLE;
            end else begin
                sc = i - 6; mx = (sc > 3) ? sc : 3; ep = 2; st = STALL;
            end
            applyStimulus(0, 1, 1, idl, 0, $sformatf("t4_c%0d", i), sc, mx, ep, 0, 0, 0, st);
        end
        applyStimulus(0, 1, 0, 0, 0, "t4_end", 0, 6, 2, 0, 0, 0, IDLE);

        $display("[TB] asynchronous reset mid-stall");
        for (int i = 1; i <= 10; i++) begin
            mx = (i > 6) ? i : 6;
            st = (i < 8) ? STALL : WARNED;
            applyStimulus(0, 1, 1, 0, 0, $sformatf("t5_c%0d", i), i, mx, 3, (i == 8), 0, 0, st);
        end
        #3;
        reset = 1'b1;
        #1;
        pushExp(0, "t5_async_reset", 0, 0, 0, 0, 0, 0, IDLE);
        checkOutput();
        #1;
        reset = 1'b0;
        applyStimulus(0, 1, 1, 0, 0, "t5_after_reset", 1, 1, 1, 0, 0, 0, STALL);
        applyStimulus(0, 1, 0, 0, 0, "t5_end", 0, 1, 1, 0, 0, 0, IDLE);

        $display("[TB] no-warning instance straight to deadlock");
        for (int i = 1; i <= 18; i++) begin
            sc = (i > 16) ? 16 : i;
            st = (i < 16) ? STALL : DEAD;
            applyStimulus(1, 1, 1, 0, 0, $sformatf("t6_c%0d", i), sc, sc, 1, 0, (i == 16), (i >= 16), st);
        end
        applyStimulus(1, 0, 0, 0, 1, "t6_clear", 0, 0, 0, 0, 0, 0, IDLE);
        for (int i = 1; i <= 7; i++)
            applyStimulus(1, 1, 1, 0, 0, $sformatf("t6_s%0d", i), i, i, 1, 0, 0, 0, STALL);
        applyStimulus(1, 0, 1, 0, 0, "t6_enable_low", 0, 7, 1, 0, 0, 0, IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/deadlock_stall_watchdog.md
Name: deadlock_stall_watchdog

Overview:
- Sits directly downstream of the per-instance HLS deadlock monitor in the co-simulation harness and consumes its registered `block` output.
- Measures how long consecutive stalls last, raises a one-cycle warning, then latches a sticky deadlock flag once a stall exceeds a timeout.
- Keeps statistics (current stall length, longest stall, stall episode count) for the testbench to report, and emits a `finish` request on deadlock.

Parameters:
- CNT_W, 32: width of all counters.
- WARN_CYCLES, 1000: stall length that triggers `warn_pulse`; 0 disables the warning.
- TIMEOUT_CYCLES, 100000: stall length that declares deadlock. Legal range: WARN_CYCLES < TIMEOUT_CYCLES < 2^CNT_W-1. Out-of-range values are an elaboration error.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  watchdog armed; low forces IDLE.
- block  in  1  stall indication from the deadlock monitor.
- inst_idle  in  1  monitored instance idle; a stall while idle is not counted.
- clear  in  1  clears sticky deadlock and statistics.
- stall_count  out  CNT_W  length of the current stall in cycles.
- max_stall  out  CNT_W  longest stall seen since reset/clear.
- episode_count  out  CNT_W  number of stall episodes started.
- warn_pulse  out  1  one-cycle pulse at the warning threshold.
- deadlock_pulse  out  1  one-cycle pulse on deadlock declaration.
- deadlock  out  1  sticky deadlock flag.
- finish_req  out  1  equals `deadlock`; the bench calls $finish on it.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all counters 0; all flags and pulses 0. A reset mid-stall or mid-deadlock abandons everything immediately.
- Qualified stall: `qb = enable & block & ~inst_idle`. It is sampled at each rising edge; all outputs are registered.
- FSM states: IDLE=0, STALL=1, WARNED=2, DEAD=3.
- IDLE:
  - If `qb`, go to STALL, set `stall_count`=1 and increment `episode_count` (saturating at all-ones).
  - Otherwise `stall_count`=0.
- STALL:
  - If `qb`, increment `stall_count`.
  - If the new value equals WARN_CYCLES, go to WARNED and drive `warn_pulse`=1 for that one cycle.
  - If `qb`=0, go to IDLE with `stall_count`=0.
- WARNED:
  - If `qb`, increment `stall_count`.
  - If the new value equals TIMEOUT_CYCLES, go to DEAD, drive `deadlock_pulse`=1 for one cycle, and set `deadlock`=1.
  - If `qb`=0, go to IDLE with `stall_count`=0.
- WARN_CYCLES=0: STALL transitions straight to DEAD at TIMEOUT_CYCLES and `warn_pulse` never fires.
- DEAD:
  - Remains until `clear`. `stall_count` freezes at TIMEOUT_CYCLES.
  - `qb`, `enable` and `inst_idle` are ignored.
- `clear` (any state, priority over everything except reset):
  - Next state IDLE; `stall_count`, `max_stall`, `episode_count` and `deadlock` go to 0.
  - A `qb` in the same cycle is dropped; counting restarts on the next `qb`.
- `max_stall` is updated every cycle to max(`max_stall`, new `stall_count`), so it tracks a stall in progress.
- `enable` low outside DEAD: next state IDLE with `stall_count`=0. Statistics are retained.
- A stall that ends exactly on a threshold cycle: only the cycle where `qb`=1 and the new count equals the threshold produces the pulse. A `qb` drop in the following cycle returns to IDLE normally.
- Pulses never overlap each other and never repeat within one episode.

Decomposition:
- Shared package (`deadlock_wd_pkg`) holds:
  - the 2-bit state enum IDLE/STALL/WARNED/DEAD;
  - the default CNT_W, WARN_CYCLES and TIMEOUT_CYCLES constants.
- One sub-module is natural: `sat_counter` (CNT_W wide, with inc/load-zero inputs and saturation), instantiated for `stall_count` and `episode_count`.
- FSM and `max_stall` comparison remain in the top module.

Test Plan (CNT_W=8, WARN_CYCLES=8, TIMEOUT_CYCLES=16):
- Block high 5 cycles, then low -> `stall_count` reads 1..5 then 0; `max_stall`=5; `episode_count`=1; no pulses.
- Block high 20 cycles -> `warn_pulse` in the cycle `stall_count`=8; `deadlock_pulse` and `deadlock` rise when the count reaches 16; count holds at 16; `finish_req`=1.
- In DEAD, assert `clear` together with `block`=1 -> next cycle state=IDLE and all stats 0; count is 1 on the following cycle if block stays high.
- Block high 12 cycles with `inst_idle`=1 during cycles 4-6 -> two episodes of 3 and 6 cycles; `episode_count`=2; `max_stall`=6; no warning.
- Assert reset asynchronously (between clock edges) at `stall_count`=10 -> all outputs 0 immediately and state=IDLE; after release, block restarts counting from 1.
- WARN_CYCLES=0 variant, block held high -> no `warn_pulse`; `deadlock_pulse` at count 16; `enable` low mid-stall at count 7 -> IDLE, count 0, `max_stall`=7.
